// File: rtl/jtpang_objdma_ctrl.sv
// ---------------------------------------------------------------------------
// jtpang_objdma_ctrl
//
// Object DMA controller. A CPU trigger makes the block request the CPU bus.
// Once the bus is granted it copies LEN bytes from VRAM (addresses 0..LEN-1)
// into the object buffer, one byte per cen cycle. It then releases the bus
// and pulses done. A trigger that arrives while a copy is in progress is
// remembered, and one more copy runs right after the current one.
//
// Optional feature, guarded by the macro JTPANG_DMA_TIMEOUT_EN:
//   Abandon a bus request that is not granted within 4095 cen cycles, and
//   pulse the extra output 'timeout'.
//
// Parameters
//   AW   width of the VRAM source address and of the object-buffer address
//   LEN  bytes per transfer (1 <= LEN <= 2**AW)
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   cen       in   copy-rate clock enable
//   dma_go    in   CPU DMA trigger (one-clk pulse)
//   busrq     out  bus request to the CPU (registered)
//   busak_n   in   bus acknowledge from the CPU, active low
//   dma_addr  out  VRAM read address
//   dma_din   in   VRAM read data, valid one clk after dma_addr
//   buf_we    out  object-buffer write strobe
//   buf_addr  out  object-buffer write address
//   buf_din   out  object-buffer write data
//   busy      out  high from the accepted trigger until the bus is released
//   done      out  one-clk pulse when the bus is released after a copy
//   timeout   out  (JTPANG_DMA_TIMEOUT_EN only) one-clk pulse on abandon
// ---------------------------------------------------------------------------
module jtpang_objdma_ctrl #(
  parameter int AW  = 9,
  parameter int LEN = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dma_go,
  output logic          busrq,
  input  logic          busak_n,
  output logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_din,
  output logic          busy,
  output logic          done
`ifdef JTPANG_DMA_TIMEOUT_EN
  ,
  output logic          timeout
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_COPY = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);

  state_t        state_q, state_d;
  logic          busrq_q, busrq_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] dma_addr_q, dma_addr_d;
  logic          buf_we_q, buf_we_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;

`ifdef JTPANG_DMA_TIMEOUT_EN
  logic [11:0]   tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // Leaving REL consumes any pending trigger, so this decode is shared by
  // the pending-flag logic and the REL branch of the FSM.
  logic rel_exit;
  assign rel_exit = (state_q == ST_REL) && busak_n;

  always_comb begin
    state_d    = state_q;
    busrq_d    = busrq_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pend_d     = pend_q;
    dma_addr_d = dma_addr_q;
    buf_we_d   = 1'b0;
    buf_addr_d = buf_addr_q;
`ifdef JTPANG_DMA_TIMEOUT_EN
    tmo_cnt_d  = 12'd0;
    timeout_d  = 1'b0;
`endif

    // Only one trigger is remembered. Pulses that arrive while the flag is
    // already set fold into it.
    if (dma_go && (state_q != ST_IDLE) && !rel_exit) begin
      pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (dma_go) begin
          state_d    = ST_REQ;
          busrq_d    = 1'b1;
          busy_d     = 1'b1;
          dma_addr_d = '0;
        end
      end

      ST_REQ: begin
        if (cen && !busak_n) begin
          state_d = ST_COPY;
        end
`ifdef JTPANG_DMA_TIMEOUT_EN
        else begin
          tmo_cnt_d = tmo_cnt_q;
          if (cen) begin
            // The counter reaches 4095 on this cen cycle: give up.
            if (tmo_cnt_q == 12'd4094) begin
              state_d   = ST_IDLE;
              busrq_d   = 1'b0;
              busy_d    = 1'b0;
              pend_d    = 1'b0;
              timeout_d = 1'b1;
              tmo_cnt_d = 12'd0;
            end else begin
              tmo_cnt_d = tmo_cnt_q + 12'd1;
            end
          end
        end
`endif
      end

      ST_COPY: begin
        // A read is issued at dma_addr on each granted cen cycle. The
        // registered write strobe lines up with the VRAM data, which
        // arrives one clk later.
        if (cen && !busak_n) begin
          dma_addr_d = dma_addr_q + AW'(1);
          buf_we_d   = 1'b1;
          buf_addr_d = dma_addr_q;
          if (dma_addr_q == LAST_ADDR) begin
            state_d = ST_REL;
            busrq_d = 1'b0;
          end
        end
      end

      ST_REL: begin
        if (busak_n) begin
          done_d = 1'b1;
          pend_d = 1'b0;
          // A trigger that lands on the exit clk counts as pending.
          if (pend_q || dma_go) begin
            state_d    = ST_REQ;
            busrq_d    = 1'b1;
            dma_addr_d = '0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busrq_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      dma_addr_q <= '0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      busrq_q    <= busrq_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      dma_addr_q <= dma_addr_d;
      buf_we_q   <= buf_we_d;
      buf_addr_q <= buf_addr_d;
    end
  end

`ifdef JTPANG_DMA_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= 12'd0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  assign busrq    = busrq_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign dma_addr = dma_addr_q;
  assign buf_we   = buf_we_q;
  assign buf_addr = buf_addr_q;
  // VRAM data is already aligned with the write strobe. Gating it keeps the
  // bus at zero outside write cycles, including while in reset.
  assign buf_din  = buf_we_q ? dma_din : 8'h00;

endmodule

// File: tb/tb_jtpang_objdma_ctrl.sv
module tb_jtpang_objdma_ctrl;

  localparam int AW  = 9;
  localparam int LEN = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b1;
  logic          dma_go = 1'b0;
  logic          busrq;
  logic          busak_n = 1'b1;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_din = 8'h00;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_din;
  logic          busy;
  logic          done;
`ifdef JTPANG_DMA_TIMEOUT_EN
  logic          timeout;
`endif

  jtpang_objdma_ctrl #(.AW(AW), .LEN(LEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .dma_go   (dma_go),
    .busrq    (busrq),
    .busak_n  (busak_n),
    .dma_addr (dma_addr),
    .dma_din  (dma_din),
    .buf_we   (buf_we),
    .buf_addr (buf_addr),
    .buf_din  (buf_din),
    .busy     (busy),
    .done     (done)
`ifdef JTPANG_DMA_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // VRAM model: synchronous read, data valid one clk after the address.
  function automatic logic [7:0] vram_val(input int a);
    vram_val = 8'((a * 7 + 8'h3c) ^ (a >> 3));
  endfunction

  logic [7:0] vram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) vram[i] = vram_val(i);
  end
  always @(posedge clk) dma_din <= vram[dma_addr];

  // Environment: cen pattern and a CPU that grants 3 clks after busrq.
  int cen_mode    = 0;
  int cen_div     = 0;
  int rq_cnt      = 0;
  bit hold_off    = 1'b0;
  bit never_grant = 1'b0;

  always @(posedge clk) begin
    #1;
    if (cen_mode == 0) begin
      cen = 1'b1;
    end else begin
      cen_div = (cen_div == 2) ? 0 : cen_div + 1;
      cen = (cen_div == 0);
    end
    if (!rst_n || !busrq) begin
      rq_cnt  = 0;
      busak_n = 1'b1;
    end else begin
      if (rq_cnt < 3) rq_cnt++;
      busak_n = !((rq_cnt >= 3) && !hold_off && !never_grant);
    end
  end

  // Scoreboard: expectations pushed when a transfer is triggered.
  typedef struct {
    int addr;
    int data;
  } exp_t;
  exp_t exp_q[$];

  bit             mon_en   = 1'b0;
  int             wr_cnt   = 0;
  int             done_cnt = 0;
  logic [AW-1:0]  prev_addr = '0;
  logic           prev_cen  = 1'b0;
  logic           prev_busak = 1'b1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (buf_we) begin
        wr_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_write: got addr=%0d din=%02h, required no write", buf_addr, buf_din);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (buf_addr !== AW'(e.addr) || buf_din !== 8'(e.data)) begin
            n_fail++;
            $display("FAIL sb_write: got addr=%0d din=%02h, required addr=%0d din=%02h",
                     buf_addr, buf_din, e.addr, e.data);
          end
        end
        if (buf_addr == AW'(LEN - 1)) begin
          n_checks++;
          if (busrq !== 1'b0) begin
            n_fail++;
            $display("FAIL busrq_fall: busrq=%b on final write clk, required 0", busrq);
          end
        end
      end
      if (done) begin
        done_cnt++;
        n_checks++;
        if (prev_busak !== 1'b1) begin
          n_fail++;
          $display("FAIL done_after_release: busak_n before done=%b, required 1", prev_busak);
        end
      end
      if (dma_addr !== prev_addr && dma_addr !== '0) begin
        n_checks++;
        if (prev_cen !== 1'b1 || dma_addr !== prev_addr + AW'(1)) begin
          n_fail++;
          $display("FAIL addr_step: %0d -> %0d with cen=%b, required +1 after a cen cycle",
                   prev_addr, dma_addr, prev_cen);
        end
      end
    end
    prev_addr  = dma_addr;
    prev_cen   = cen;
    prev_busak = busak_n;
  end

  task automatic push_transfer();
    for (int i = 0; i < LEN; i++) begin
      exp_t e;
      e.addr = i;
      e.data = int'(vram_val(i));
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_go();
    @(negedge clk); #1;
    dma_go = 1'b1;
    @(negedge clk); #1;
    dma_go = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    n_checks++;
    if (done_cnt < target) begin
      n_fail++;
      $display("FAIL %s_timeout: done count %0d, required %0d within %0d clks", tag, done_cnt, target, budget);
    end
  endtask

  task automatic wait_addr(input int a, input int budget, input string tag);
    int n = 0;
    while (dma_addr !== AW'(a) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    n_checks++;
    if (dma_addr !== AW'(a)) begin
      n_fail++;
      $display("FAIL %s_reach_addr: dma_addr=%0d, required %0d", tag, dma_addr, a);
    end
  endtask

  task automatic check_copy_end(input int wr0, input int nwr, input string tag);
    n_checks++;
    if (wr_cnt - wr0 !== nwr) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d, required %0d", tag, wr_cnt - wr0, nwr);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_sb_left: %0d writes missing, required 0", tag, exp_q.size());
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || busrq !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b busrq=%b, required 0 0", tag, busy, busrq);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busrq, busy, done, buf_we} !== 4'b0 || dma_addr !== '0 || buf_addr !== '0 || buf_din !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: busrq=%b busy=%b done=%b we=%b addr=%0d baddr=%0d din=%02h, required all 0",
               busrq, busy, done, buf_we, dma_addr, buf_addr, buf_din);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (busrq !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busrq=%b busy=%b, required 0 0", busrq, busy);
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic_copy();
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    push_transfer();
    pulse_go();
    wait_done(d0 + 1, 2000, "basic");
    check_copy_end(wr0, LEN, "basic");
    $display("test_basic_copy: writes=%0d done=%0d", wr_cnt - wr0, done_cnt - d0);
  endtask

  task automatic test_grant_gap();
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    push_transfer();
    pulse_go();
    wait_addr(100, 1000, "gap");
    hold_off = 1'b1;
    busak_n  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (dma_addr !== AW'(100) || buf_we !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_freeze[%0d]: dma_addr=%0d buf_we=%b, required 100 0", i, dma_addr, buf_we);
      end
    end
    hold_off = 1'b0;
    wait_done(d0 + 1, 2000, "gap");
    check_copy_end(wr0, LEN, "gap");
    $display("test_grant_gap: writes=%0d", wr_cnt - wr0);
  endtask

  task automatic test_back_to_back();
    int wr0   = wr_cnt;
    int d0    = done_cnt;
    int drops = 0;
    int n     = 0;
    push_transfer();
    pulse_go();
    wait_addr(50, 1000, "b2b");
    push_transfer();  // three extra pulses must yield exactly one more copy
    pulse_go();
    @(negedge clk);
    pulse_go();
    @(negedge clk);
    pulse_go();
    while (done_cnt < d0 + 2 && n < 4000) begin
      @(negedge clk); #1;
      n++;
      if (done_cnt < d0 + 2 && busy !== 1'b1) drops++;
    end
    n_checks++;
    if (done_cnt !== d0 + 2) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d, required 2", done_cnt - d0);
    end
    n_checks++;
    if (drops != 0) begin
      n_fail++;
      $display("FAIL b2b_busy_hold: busy low on %0d clks, required 0", drops);
    end
    repeat (20) @(negedge clk);
    #1;
    n_checks++;
    if (done_cnt !== d0 + 2) begin
      n_fail++;
      $display("FAIL b2b_no_third: done count %0d, required 2", done_cnt - d0);
    end
    check_copy_end(wr0, 2 * LEN, "b2b");
    $display("test_back_to_back: writes=%0d done=%0d", wr_cnt - wr0, done_cnt - d0);
  endtask

  task automatic test_reset_mid_copy();
    int wr0;
    int d0;
    push_transfer();
    pulse_go();
    wait_addr(200, 1000, "rst");
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_checks++;
    if (busrq !== 1'b0 || buf_we !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort: busrq=%b buf_we=%b busy=%b, required 0 0 0", busrq, buf_we, busy);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    mon_en = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || busrq !== 1'b0 || dma_addr !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle: busy=%b busrq=%b dma_addr=%0d done=%b, required 0 0 0 0",
               busy, busrq, dma_addr, done);
    end
    wr0 = wr_cnt;
    d0  = done_cnt;
    push_transfer();
    pulse_go();
    wait_done(d0 + 1, 2000, "rst");
    check_copy_end(wr0, LEN, "rst");
    $display("test_reset_mid_copy: writes after reset=%0d", wr_cnt - wr0);
  endtask

  task automatic test_cen_div3();
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    cen_mode = 1;
    push_transfer();
    pulse_go();
    wait_done(d0 + 1, 5000, "cen3");
    check_copy_end(wr0, LEN, "cen3");
    cen_mode = 0;
    $display("test_cen_div3: writes=%0d", wr_cnt - wr0);
  endtask

`ifdef JTPANG_DMA_TIMEOUT_EN
  task automatic test_timeout();
    int d0  = done_cnt;
    int req = 0;
    int n   = 0;
    never_grant = 1'b1;
    @(negedge clk); #1;
    dma_go = 1'b1;
    @(negedge clk); #1;
    dma_go = 1'b0;
    if (busrq === 1'b1) req++;
    while (timeout !== 1'b1 && n < 6000) begin
      @(negedge clk); #1;
      n++;
      if (busrq === 1'b1) req++;
    end
    n_checks++;
    if (req !== 4095) begin
      n_fail++;
      $display("FAIL tmo_latency: busrq held %0d clks before timeout, required 4095", req);
    end
    n_checks++;
    if (timeout !== 1'b1 || busrq !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_state: timeout=%b busrq=%b busy=%b, required 1 0 0", timeout, busrq, busy);
    end
    @(negedge clk); #1;
    n_checks++;
    if (timeout !== 1'b0 || done_cnt !== d0) begin
      n_fail++;
      $display("FAIL tmo_pulse: timeout=%b dones=%0d, required 0 0", timeout, done_cnt - d0);
    end
    never_grant = 1'b0;
    $display("test_timeout: busrq clks=%0d", req);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_copy();
    test_grant_gap();
    test_back_to_back();
    test_reset_mid_copy();
    test_cen_div3();
`ifdef JTPANG_DMA_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
